// File: rtl/gf_pkg.sv
// Shared GF(2^n) definitions: controller state encoding, common reduction
// polynomials and the xtime (multiply-by-x) helper used by the step kernel.
package gf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] GF_POLY_AES = 8'h1B;
  localparam logic [7:0] GF_POLY_RS  = 8'h1D;

  // Works on any width up to 16; bits above 'width' are forced to zero.
  function automatic logic [15:0] xtime(input logic [15:0] x,
                                        input int          width,
                                        input logic [15:0] poly);
    logic [15:0] mask;
    logic [15:0] shifted;
    logic        msb;
    mask    = 16'((17'd1 << width) - 17'd1);
    msb     = |(x & (16'd1 << (width - 1)));
    shifted = (x << 1) & mask;
    return msb ? (shifted ^ (poly & mask)) : shifted;
  endfunction

endpackage

// File: rtl/gf_mul_seq_if.sv
// Operand/product handshake bundle for the sequential GF multiplier.
interface gf_mul_seq_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_p;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, busy
  );

endinterface

// File: rtl/gf_step.sv
// One Horner iteration of GF(2^WIDTH) multiplication:
// acc_next = xtime(acc) ^ (bit_in ? a : 0).
module gf_step
  import gf_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(GF_POLY_AES)
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] a,
  input  logic             bit_in,
  output logic [WIDTH-1:0] acc_next
);

  always_comb begin
    acc_next = WIDTH'(xtime(16'(acc), WIDTH, 16'(POLY))) ^ (bit_in ? a : '0);
  end

endmodule

// File: rtl/gf_mul_seq.sv
// Multi-cycle GF(2^WIDTH) multiplier: accepts an operand pair, runs WIDTH
// MSB-first Horner steps through gf_step, then holds the product until taken.
module gf_mul_seq
  import gf_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(GF_POLY_AES)
) (
  input logic          clk,
  input logic          rst,
  gf_mul_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_step;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             handoff;
  logic             last_step;

  assign accept    = (state == IDLE) & bus.in_valid;
  assign handoff   = (state == DONE) & bus.out_ready;
  assign last_step = (cnt_q == '0);

  gf_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .acc      (acc_q),
    .a        (a_q),
    .bit_in   (b_q[cnt_q]),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (handoff)   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Operands are captured only on accept, so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      a_q   <= bus.in_a;
      b_q   <= bus.in_b;
      acc_q <= '0;
      cnt_q <= CNT_W'(WIDTH - 1);
    end else if (state == RUN) begin
      acc_q <= acc_step;
      if (!last_step) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state == RUN) | (state == DONE);
    bus.out_p     = (state == DONE) ? acc_q : '0;
  end

endmodule

// File: tb/tb_gf_mul_seq.sv
// Randomized self-checking bench for gf_mul_seq against a carry-less
// multiply-then-reduce reference model.
module tb_gf_mul_seq;
  import gf_pkg::*;

  localparam int         WIDTH = 8;
  localparam logic [7:0] POLY  = GF_POLY_AES;

  logic clk = 1'b0;
  logic rst;
  int   checks     = 0;
  int   errors     = 0;
  int   cycleCnt   = 0;
  int   lastAccept = -1;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  gf_mul_seq_if #(.WIDTH(WIDTH)) bus ();

  gf_mul_seq #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Full polynomial product first, then long division by x^8 + POLY.
  function automatic logic [7:0] gfRef(input logic [7:0] a, input logic [7:0] b);
    int prod    = 0;
    int av      = int'(a);
    int bv      = int'(b);
    int modulus = 32'h100 | int'(POLY);
    for (int i = 0; i < 8; i++)
      if (((bv >> i) & 1) != 0) prod = prod ^ (av << i);
    for (int i = 14; i >= 8; i--)
      if (((prod >> i) & 1) != 0) prod = prod ^ (modulus << (i - 8));
    return 8'(prod);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called and returns at a negedge; one complete accept/compute/handoff.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input int holdCycles, input bit scramble,
                               input bit checkSpacing);
    logic [7:0] expP;
    logic [7:0] held;
    int         waited;
    int         acceptCnt;
    bit         seen;
    expP          = gfRef(a, b);
    bus.out_ready = (holdCycles == 0);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    waited        = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    acceptCnt    = cycleCnt;
    bus.in_valid = 1'b0;
    checkOutput("run_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("run_busy", 32'(bus.busy), 32'd1);
    if (checkSpacing && lastAccept >= 0)
      checkOutput("accept_spacing", acceptCnt - lastAccept, WIDTH + 2);
    lastAccept = acceptCnt;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.out_valid) begin
        seen = 1'b1;
      end else begin
        if (scramble) begin
          bus.in_a = 8'($urandom);
          bus.in_b = 8'($urandom);
        end
        @(negedge clk);
      end
    end
    if (!seen) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("latency", cycleCnt - acceptCnt, WIDTH);
    checkOutput("product", 32'(bus.out_p), 32'(expP));
    held = bus.out_p;
    for (int i = 0; i < holdCycles; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 8'($urandom);
      bus.in_b     = 8'($urandom);
      @(negedge clk);
      checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("hold_p", 32'(bus.out_p), 32'(held));
      checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("idle_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("idle_out_p", 32'(bus.out_p), 32'd0);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit sawValid;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_out_p", 32'(bus.out_p), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(8'h57, 8'h83, 0, 1'b0, 1'b0);
    applyStimulus(8'h02, 8'h80, 0, 1'b0, 1'b0);
    applyStimulus(8'hA5, 8'h01, 0, 1'b0, 1'b0);
    applyStimulus(8'hA5, 8'h00, 0, 1'b0, 1'b0);
    applyStimulus(8'h01, 8'h3C, 0, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'hFF, 0, 1'b0, 1'b0);

    applyStimulus(8'($urandom), 8'($urandom), 5, 1'b0, 1'b0);

    // Reset lands in the fourth RUN cycle; the dropped product must never appear.
    bus.in_valid = 1'b1;
    bus.in_a     = 8'h57;
    bus.in_b     = 8'h83;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrun_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("midrun_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrun_out_p", 32'(bus.out_p), 32'd0);
    checkOutput("midrun_busy", 32'(bus.busy), 32'd0);
    sawValid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) sawValid = 1'b1;
    end
    checkOutput("midrun_no_product", 32'(sawValid), 32'd0);

    applyStimulus(8'hC3, 8'h5E, 0, 1'b1, 1'b0);
    applyStimulus(8'($urandom), 8'($urandom), 0, 1'b1, 1'b0);

    for (int n = 0; n < 16; n++)
      applyStimulus(8'($urandom), 8'($urandom), 0, 1'b0, n != 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
